bcd_updown_counter_display: RTL
===============================

Name: bcd_updown_counter_display

Overview:
Multi-digit decimal (BCD) up/down counter with synchronous load, enable, and wrap/saturate terminal behaviour. Drives a time-multiplexed common-anode seven-segment display, one digit per scan slot. It is the parametrised successor of the single-nibble up/down counter with static decoder, and sits between board push-button/clock-enable logic and the display pins.

Parameters:
DIGITS, 4, number of BCD digits (1..8); count width = 4*DIGITS
SCAN_DIV, 1000, clk cycles each digit is held active during display scan (>=2)
SEG_ACTIVE_LOW, 1, 1: segment/anode outputs active-low; 0: active-high

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
en  in  1  count enable, one step per clk with en=1
mode  in  1  0 = count up, 1 = count down
saturate  in  1  0 = wrap at limits, 1 = hold at limits
load  in  1  synchronous load strobe
load_val  in  4*DIGITS  BCD value to load, digit 0 in bits [3:0]
count_bcd  out  4*DIGITS  current BCD count, registered
tc  out  1  terminal-count pulse
seg  out  7  segments {a,b,c,d,e,f,g}, registered
an  out  DIGITS  digit enables, one-hot, registered

Behaviour:
- Reset, asynchronous: count_bcd=0; tc=0; scan divider=0; digit index=0; seg=all off; an=all off (polarity per SEG_ACTIVE_LOW).
- Priority each edge: reset > load > en. With load=1: count_bcd <= load_val, where any nibble >9 is clamped to 9. tc=0. en is ignored.
- Count step, en=1 and load=0, 1-cycle latency:
  - up: digit 0 +1; a digit at 9 becomes 0 and carries into the next digit.
  - down: digit 0 -1; a digit at 0 becomes 9 and borrows from the next digit.
- Limits, MAX = all digits 9, MIN = 0:
  - up from MAX: saturate=0 -> 0; saturate=1 -> stays MAX.
  - down from MIN: saturate=0 -> MAX; saturate=1 -> stays MIN.
- tc: high for exactly the cycle after any step attempted from MAX (up) or MIN (down), in either saturate mode. In saturate mode, tc is high every such attempted step. Otherwise tc=0.
- en=0: count holds; tc=0. mode and saturate may change on any cycle; they take effect on the next step.
- Scan:
  - Free-running divider counts 0..SCAN_DIV-1 independent of en. On wrap, the digit index advances 0..DIGITS-1, then back to 0.
  - an asserts only the indexed digit.
  - seg = decode of count_bcd digit[index], registered with the same timing as an, so both change on the same edge.
  - First an/seg update occurs on the first clk edge after reset deasserts.
- Decode, active-high form {a..g}; inverted when SEG_ACTIVE_LOW=1:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - other codes = 0000000 (blank)
- DIGITS=1: an is constantly asserted after reset.

Decomposition:
- Package bcd_disp_pkg holds:
  - 7-bit segment constants SEG_0..SEG_9 and SEG_BLANK (active-high form)
  - function seg_decode(nibble)
  - function bcd_clamp(nibble)
- One sub-module, bcd_digit_cell: a single-digit up/down cell with carry/borrow in, carry/borrow out, and is_max/is_min flags. Instantiate it DIGITS times via generate.

Test Plan:
- Reset mid-count at 0x0427 -> count_bcd=0, tc=0, seg/an all off immediately, without waiting for a clk edge.
- DIGITS=4, load 0x0998, mode=0, en=1 for 3 cycles -> 0x0999, 0x1000, 0x1001; tc stays 0.
- load 0x9999, saturate=0, up one step -> 0x0000, tc=1 for one cycle. Then mode=1, one step -> 0x9999, tc=1.
- load 0x0000, saturate=1, mode=1, en=1 for 3 cycles -> count stays 0x0000, tc=1 each cycle. Drop en -> tc=0.
- load 0x12F4 -> count_bcd=0x1294 (nibble clamped). Load and en both high -> load wins.
- SCAN_DIV=4, count 0x0123, SEG_ACTIVE_LOW=1:
  - an cycles 1110, 1101, 1011, 0111, changing every 4 clks.
  - seg = 0000110, 0010010, 1001111, 0000001 respectively (digits 3, 2, 1, 0).

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the BCD up/down counter display.
// Holds active-high segment codes {a..g}, seg_decode and bcd_clamp.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return (nibble > 4'd9) ? 4'd9 : nibble;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_display_cell.sv
// Single BCD digit up/down step cell (combinational).
// Ports: digit in, mode, cin (step request) -> next digit, cout, is_max, is_min.
module bcd_digit_cell (
    input  logic       mode,
    input  logic       cin,
    input  logic [3:0] digit,
    output logic [3:0] next,
    output logic       cout,
    output logic       is_max,
    output logic       is_min
);
    assign is_max = (digit == 4'd9);
    assign is_min = (digit == 4'd0);

    // A digit only passes the step on when it rolls over in the step direction.
    assign cout = cin & (mode ? is_min : is_max);

    always_comb begin
        next = digit;
        if (cin) begin
            if (!mode) next = is_max ? 4'd0 : digit + 4'd1;
            else       next = is_min ? 4'd9 : digit - 4'd1;
        end
    end
endmodule

// File: rtl/bcd_updown_counter_display.sv
// Multi-digit BCD up/down counter driving a multiplexed 7-segment display.
// Ports: clk, reset, en, mode, saturate, load, load_val -> count_bcd, tc, seg, an.
module bcd_updown_counter_display
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  saturate,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  tc,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);
    localparam int W  = 4 * DIGITS;
    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? '1 : '0;
    localparam logic [DIGITS-1:0] AN_OFF  = SEG_ACTIVE_LOW ? '1 : '0;

    logic [W-1:0]      nxt_count;
    logic [W-1:0]      load_clamped;
    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] is_max;
    logic [DIGITS-1:0] is_min;
    logic              at_limit;

    assign carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_cell
        bcd_digit_cell u_cell (
            .mode   (mode),
            .cin    (carry[g]),
            .digit  (count_bcd[4*g +: 4]),
            .next   (nxt_count[4*g +: 4]),
            .cout   (carry[g+1]),
            .is_max (is_max[g]),
            .is_min (is_min[g])
        );
    end

    assign at_limit = mode ? (&is_min) : (&is_max);

    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++)
            load_clamped[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
    end

    // Carry out of the top digit marks a step attempted from MAX/MIN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_bcd <= '0;
            tc        <= 1'b0;
        end else if (load) begin
            count_bcd <= load_clamped;
            tc        <= 1'b0;
        end else if (en) begin
            tc <= carry[DIGITS];
            if (!(saturate && at_limit))
                count_bcd <= nxt_count;
        end else begin
            tc <= 1'b0;
        end
    end

    logic [DW-1:0]     div;
    logic [IW-1:0]     idx;
    logic [DIGITS-1:0] an_hot;
    logic [3:0]        cur_digit;

    always_comb begin
        an_hot    = '0;
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                an_hot[i] = 1'b1;
                cur_digit = count_bcd[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
            idx <= '0;
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            if (div == DW'(SCAN_DIV - 1)) begin
                div <= '0;
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
            seg <= SEG_ACTIVE_LOW ? ~seg_decode(cur_digit) : seg_decode(cur_digit);
            an  <= SEG_ACTIVE_LOW ? ~an_hot : an_hot;
        end
    end
endmodule
